// File: rtl/rv_bus_arbiter_if.sv
// rv_bus_arbiter_if: fetch, data and shared-bus signals of the memory bus arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding pipeline and bus.
interface rv_bus_arbiter_if;
    logic        i_if_req;
    logic [29:0] i_if_addr;
    logic        o_if_ack;
    logic        o_if_err;
    logic [31:0] o_if_rdata;
    logic        o_if_stall;
    logic        i_d_req;
    logic        i_d_write;
    logic [31:0] i_d_addr;
    logic [3:0]  i_d_sel;
    logic [31:0] i_d_wdata;
    logic        o_d_ack;
    logic        o_d_err;
    logic [31:0] o_d_rdata;
    logic        o_d_stall;
    logic        o_bus_stb;
    logic        o_bus_we;
    logic [29:0] o_bus_addr;
    logic [3:0]  o_bus_sel;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    modport master (
        input  i_if_req, i_if_addr, i_d_req, i_d_write, i_d_addr, i_d_sel, i_d_wdata, i_bus_ack, i_bus_rdata,
        output o_if_ack, o_if_err, o_if_rdata, o_if_stall, o_d_ack, o_d_err, o_d_rdata, o_d_stall,
        output o_bus_stb, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata
    );
    modport slave (
        output i_if_req, i_if_addr, i_d_req, i_d_write, i_d_addr, i_d_sel, i_d_wdata, i_bus_ack, i_bus_rdata,
        input  o_if_ack, o_if_err, o_if_rdata, o_if_stall, o_d_ack, o_d_err, o_d_rdata, o_d_stall,
        input  o_bus_stb, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata
    );
endinterface

// File: rtl/rv_bus_arbiter.sv
// rv_bus_arbiter: single-port bus arbiter between fetch and load/store, data-first with a fetch
// starvation guard and a grant timeout that completes the stuck requester with an error.
module rv_bus_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 16
) (
    input logic               i_clk,
    input logic               i_reset,
    rv_bus_arbiter_if.master  bus
);
    localparam int SW = $clog2(STARVE_LIM + 1) > 0 ? $clog2(STARVE_LIM + 1) : 1;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} state_t;
    state_t      state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        bus_we_q, bus_we_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        gd, gi, starve, tmo_hit, done;
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^bus.i_d_addr[1:0];
    always_comb begin
        gd          = state_q == GRANT_D;
        gi          = state_q == GRANT_I;
        starve      = (STARVE_LIM != 0) && (starve_q >= SW'(STARVE_LIM));
        tmo_hit     = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1)) && !bus.i_bus_ack;
        done        = (gd || gi) && (bus.i_bus_ack || tmo_hit);
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q + TW'(1);
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        if (state_q == IDLE) begin
            tmo_d = '0;
            if (bus.i_d_req && !starve) begin
                state_d     = GRANT_D;
                bus_we_d    = bus.i_d_write;
                bus_addr_d  = bus.i_d_addr[31:2];
                bus_sel_d   = bus.i_d_sel;
                bus_wdata_d = bus.i_d_wdata;
                starve_d    = (bus.i_if_req && starve_q < SW'(STARVE_LIM)) ? starve_q + SW'(1) : starve_q;
            end else if (bus.i_if_req) begin
                state_d     = GRANT_I;
                bus_we_d    = 1'b0;
                bus_addr_d  = bus.i_if_addr;
                bus_sel_d   = 4'b1111;
                bus_wdata_d = '0;
                starve_d    = '0;
            end
        end else if (done) begin
            // Completion frees the bus; the next owner is chosen from fresh requests in IDLE.
            state_d     = IDLE;
            bus_we_d    = 1'b0;
            bus_addr_d  = '0;
            bus_sel_d   = '0;
            bus_wdata_d = '0;
        end
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end
    assign bus.o_bus_stb   = gd || gi;
    assign bus.o_bus_we    = bus_we_q;
    assign bus.o_bus_addr  = bus_addr_q;
    assign bus.o_bus_sel   = bus_sel_q;
    assign bus.o_bus_wdata = bus_wdata_q;
    assign bus.o_d_ack     = gd && (bus.i_bus_ack || tmo_hit);
    assign bus.o_d_err     = gd && tmo_hit;
    assign bus.o_d_rdata   = (gd && bus.i_bus_ack) ? bus.i_bus_rdata : '0;
    assign bus.o_d_stall   = bus.i_d_req && !bus.o_d_ack;
    assign bus.o_if_ack    = gi && (bus.i_bus_ack || tmo_hit);
    assign bus.o_if_err    = gi && tmo_hit;
    assign bus.o_if_rdata  = (gi && bus.i_bus_ack) ? bus.i_bus_rdata : '0;
    assign bus.o_if_stall  = bus.i_if_req && !bus.o_if_ack;
endmodule

// File: doc/rv_bus_arbiter.md
Name: rv_bus_arbiter

Overview:
- Single-port memory bus arbiter between the instruction-fetch requester and the memory-stage (load/store) requester.
- Grants one requester at a time onto the shared bus, with data priority and a fetch starvation guard.
- Provides a bus timeout and stall outputs for the pipeline hazard logic.
- Sits between the fetch/memory stages and the external memory/peripheral bus.

Parameters:
- STARVE_LIM, 4: consecutive arbitration losses by a pending fetch before fetch gets priority; 0 disables the guard.
- TIMEOUT, 16: cycles in a grant state without i_bus_ack before an error completion; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_if_req  in  1  fetch request; held with address until o_if_ack.
- i_if_addr  in  30  fetch word address [31:2].
- o_if_ack  out  1  fetch completion, one cycle.
- o_if_err  out  1  fetch timed out; valid with o_if_ack.
- o_if_rdata  out  32  fetch data; valid with o_if_ack.
- o_if_stall  out  1  equals i_if_req & ~o_if_ack.
- i_d_req  in  1  data request; held with all data fields until o_d_ack.
- i_d_write  in  1  1 = store, 0 = load.
- i_d_addr  in  32  byte address.
- i_d_sel  in  4  byte lane enables.
- i_d_wdata  in  32  lane-replicated store data.
- o_d_ack  out  1  data completion, one cycle.
- o_d_err  out  1  data timed out; valid with o_d_ack.
- o_d_rdata  out  32  load data; valid with o_d_ack.
- o_d_stall  out  1  equals i_d_req & ~o_d_ack.
- o_bus_stb  out  1  bus request strobe.
- o_bus_we  out  1  bus write enable.
- o_bus_addr  out  30  bus word address [31:2].
- o_bus_sel  out  4  bus byte enables.
- o_bus_wdata  out  32  bus write data.
- i_bus_ack  in  1  bus completion; valid only while o_bus_stb=1.
- i_bus_rdata  in  32  bus read data; valid with i_bus_ack.

Behaviour:
- FSM states: IDLE, GRANT_D, GRANT_I.
- Reset (asynchronous, immediate, also mid-transaction):
  - state = IDLE; starvation counter = 0; timeout counter = 0.
  - All bus outputs = 0 (o_bus_stb drops at once); all acks and errs = 0.
  - An in-flight bus transaction is abandoned with no completion reported.
- IDLE arbitration, per edge:
  - i_d_req & !(starve) -> GRANT_D.
  - Otherwise i_if_req -> GRANT_I.
  - Otherwise stay IDLE.
  - starve = (STARVE_LIM != 0) & (starvation counter >= STARVE_LIM).
- Bus fields are registered on the edge entering a grant state and held constant for the whole grant.
  - GRANT_D: we = i_d_write, addr = i_d_addr[31:2], sel = i_d_sel, wdata = i_d_wdata.
  - GRANT_I: we = 0, addr = i_if_addr, sel = 4'b1111, wdata = 0.
  - o_bus_stb = 1 exactly while in a grant state.
- Completion is combinational:
  - o_x_ack = i_bus_ack while granted to x.
  - o_x_rdata = i_bus_rdata when o_x_ack=1, otherwise 0.
  - The same edge returns the FSM to IDLE and clears bus fields and stb.
  - The requester must drop or change its request on that edge, so re-arbitration next cycle sees only fresh requests.
- Minimum latency: request sampled at edge N; stb high in cycle N+1; with 0-wait ack, o_ack in cycle N+1.
  - Throughput: one transfer per 2 cycles, since IDLE costs one cycle between grants.
- Starvation counter:
  - Increments, saturating at STARVE_LIM, on each IDLE->GRANT_D edge while i_if_req=1.
  - Clears on IDLE->GRANT_I.
  - Both requests pending with the counter below the limit: data wins.
- Timeout counter:
  - Clears on entering a grant state; increments each grant cycle without ack.
  - When it reaches TIMEOUT-1 with no ack: o_x_ack=1 and o_x_err=1 for that cycle, o_x_rdata=0, FSM -> IDLE.
  - i_bus_ack in the same cycle takes precedence: normal completion, err=0.
- i_bus_ack while IDLE is ignored.
- Requests asserted while the other requester is granted wait. Stall stays high until that requester's own ack.
- A store that times out has no side effect guaranteed.

Test Plan:
- Reset, then i_d_req store addr 0x100, sel 4'b0011, wdata 0xBEEFBEEF -> next cycle stb=1, we=1, addr=0x40, sel=0011; 0-wait ack -> o_d_ack=1, o_d_err=0, o_d_stall=0.
- Simultaneous i_if_req (addr 0x10) and i_d_req load -> GRANT_D first, o_if_stall=1 throughout; after data ack, IDLE then GRANT_I with o_bus_addr=0x10, sel=1111.
- Continuous data requests plus pending fetch, STARVE_LIM=4 -> exactly 4 data grants, then fetch granted; counter clears.
- Bus never acks, TIMEOUT=16 -> o_d_ack=1 and o_d_err=1 in the 16th grant cycle, o_d_rdata=0, stb low the next cycle.
- Fetch with 3 wait states and ack rdata 0x00000013 -> o_if_ack=1 with rdata=0x13 in the 4th stb cycle; ack in IDLE produces no output.
- Assert i_reset mid-grant -> o_bus_stb=0 combinationally, no ack; after release a fresh request is granted normally.
